// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard controller with a halt state and run/stall/bubble statistics counters.
// Pipeline-register controls are purely combinational in RUN and are forced to a frozen pattern once halted.
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  D_icode_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    input  logic [3:0]  E_icode_i,
    input  logic [3:0]  E_dstM_i,
    input  logic        e_Cnd_i,
    input  logic [3:0]  M_icode_i,
    input  logic [3:0]  m_stat_i,
    input  logic [3:0]  W_stat_i,
    output logic        F_stall_o,
    output logic        D_stall_o,
    output logic        D_bubble_o,
    output logic        E_bubble_o,
    output logic        M_bubble_o,
    output logic        W_stall_o,
    output logic        halted_o,
    output logic [3:0]  stat_o,
    output logic [31:0] cyc_cnt_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] bubble_cnt_o
);

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] SAOK    = 4'h1;
    localparam logic [3:0] SADR    = 4'h2;
    localparam logic [3:0] SINS    = 4'h3;
    localparam logic [3:0] SHLT    = 4'h4;

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_stat;
    logic [31:0] r_cyc_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;

    logic w_load_use;
    logic w_ret_pend;
    logic w_mispred;
    logic w_m_exc;
    logic w_w_exc;

    always_comb begin
        w_load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                     (E_dstM_i != RNONE) &&
                     ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        w_ret_pend = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        w_mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
        w_m_exc    = (m_stat_i == SADR) || (m_stat_i == SINS) || (m_stat_i == SHLT);
        w_w_exc    = (W_stat_i == SADR) || (W_stat_i == SINS) || (W_stat_i == SHLT);
    end

    always_comb begin
        w_state_nxt = r_state;
        F_stall_o   = 1'b0;
        D_stall_o   = 1'b0;
        D_bubble_o  = 1'b0;
        E_bubble_o  = 1'b0;
        M_bubble_o  = 1'b0;
        W_stall_o   = 1'b0;
        halted_o    = 1'b0;
        case (r_state)
            S_RUN: begin
                F_stall_o  = w_load_use || w_ret_pend;
                // A mispredict squashes D, so it must not also be stalled.
                D_stall_o  = w_load_use && !w_mispred;
                D_bubble_o = w_mispred || (w_ret_pend && !w_load_use);
                E_bubble_o = w_mispred || w_load_use;
                M_bubble_o = w_m_exc || w_w_exc;
                W_stall_o  = w_w_exc;
                if (w_w_exc) w_state_nxt = S_HALTED;
            end
            S_HALTED: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_bubble_o = 1'b1;
                M_bubble_o = 1'b1;
                W_stall_o  = 1'b1;
                halted_o   = 1'b1;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_RUN;
            r_stat       <= SAOK;
            r_cyc_cnt    <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RUN) begin
                if (w_w_exc) r_stat <= W_stat_i;
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
                if (F_stall_o && (r_stall_cnt != '1))
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                if (E_bubble_o && (r_bubble_cnt != '1))
                    r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign stat_o       = r_stat;
    assign cyc_cnt_o    = r_cyc_cnt;
    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: hazard controls, halt latching, counters, async reset and saturation.
module tb_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i, m_stat_i, W_stat_i;
    logic        e_Cnd_i;
    logic        F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, halted_o;
    logic [3:0]  stat_o;
    logic [31:0] cyc_cnt_o;
    logic [15:0] stall_cnt_o, bubble_cnt_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pipe_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
        .M_icode_i(M_icode_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
        .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o), .W_stall_o(W_stall_o),
        .halted_o(halted_o), .stat_o(stat_o), .cyc_cnt_o(cyc_cnt_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controls packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}.
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o},
            {26'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] cyc, input logic [15:0] st,
                           input logic [15:0] bu);
        chk({tag, "_cyc"}, cyc_cnt_o, cyc);
        chk({tag, "_stall"}, {16'd0, stall_cnt_o}, {16'd0, st});
        chk({tag, "_bubble"}, {16'd0, bubble_cnt_o}, {16'd0, bu});
    endtask

    task automatic idle();
        D_icode_i = 4'h1; d_srcA_i = 4'hF; d_srcB_i = 4'hF;
        E_icode_i = 4'h1; E_dstM_i = 4'hF; e_Cnd_i = 1'b1;
        M_icode_i = 4'h1; m_stat_i = 4'h1; W_stat_i = 4'h1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        #3;
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_stat", {28'd0, stat_o}, 32'h1);
        chk_cnt("rst", 32'd0, 16'd0, 16'd0);
        chk_ctl("rst_ctl", 6'b000000);
        @(negedge clk_i);
        rst_i = 1'b0;

        tick();
        chk_ctl("idle_ctl", 6'b000000);
        chk_cnt("idle", 32'd1, 16'd0, 16'd0);

        E_icode_i = 4'h5; E_dstM_i = 4'h0; d_srcA_i = 4'h0;
        #1 chk_ctl("loaduse_mr", 6'b110100);
        tick();
        chk_cnt("loaduse", 32'd2, 16'd1, 16'd1);

        idle();
        E_icode_i = 4'hB; E_dstM_i = 4'h3; d_srcB_i = 4'h3;
        #1 chk_ctl("loaduse_pop", 6'b110100);
        E_dstM_i = 4'hF; d_srcA_i = 4'hF; d_srcB_i = 4'hF;
        #1 chk_ctl("loaduse_rnone", 6'b000000);

        idle();
        E_icode_i = 4'h7; e_Cnd_i = 1'b0;
        #1 chk_ctl("mispred", 6'b001100);
        tick();
        chk_cnt("mispred", 32'd3, 16'd1, 16'd2);
        e_Cnd_i = 1'b1;
        #1 chk_ctl("jxx_taken", 6'b000000);

        rst_i = 1'b1;
        #1 chk_cnt("midrst", 32'd0, 16'd0, 16'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle();

        D_icode_i = 4'h9;
        #1 chk_ctl("ret_D", 6'b101000);
        tick();
        idle(); E_icode_i = 4'h9;
        #1 chk_ctl("ret_E", 6'b101000);
        tick();
        idle(); M_icode_i = 4'h9;
        #1 chk_ctl("ret_M", 6'b101000);
        tick();
        chk_cnt("ret", 32'd3, 16'd3, 16'd0);

        idle();
        m_stat_i = 4'h2;
        #1 chk_ctl("m_sadr", 6'b000010);
        m_stat_i = 4'h3;
        #1 chk_ctl("m_sins", 6'b000010);
        m_stat_i = 4'h0;
        #1 chk_ctl("m_nonexc", 6'b000000);

        idle();
        D_icode_i = 4'h9; E_icode_i = 4'h5; E_dstM_i = 4'h2; d_srcA_i = 4'h2;
        #1 chk_ctl("combo", 6'b110100);
        tick();
        chk_cnt("combo", 32'd4, 16'd4, 16'd1);

        idle();
        m_stat_i = 4'h4;
        #1 chk_ctl("halt_m", 6'b000010);
        tick();
        chk({"halt_m_halted"}, {31'd0, halted_o}, 32'd0);
        m_stat_i = 4'h1; W_stat_i = 4'h4;
        #1 chk_ctl("halt_w", 6'b000011);
        tick();
        chk("halted", {31'd0, halted_o}, 32'd1);
        chk("halted_stat", {28'd0, stat_o}, 32'h4);
        chk_ctl("halted_ctl", 6'b110111);
        chk_cnt("halt", 32'd6, 16'd4, 16'd1);

        W_stat_i = 4'h2; D_icode_i = 4'h9; E_icode_i = 4'h7; e_Cnd_i = 1'b0;
        m_stat_i = 4'h1;
        for (int i = 0; i < 3; i++) tick();
        W_stat_i = 4'h1; E_icode_i = 4'h5; E_dstM_i = 4'h2; d_srcA_i = 4'h2;
        #1 chk_ctl("halted_frozen_ctl", 6'b110111);
        chk("halted_frozen_stat", {28'd0, stat_o}, 32'h4);
        chk_cnt("halted_frozen", 32'd6, 16'd4, 16'd1);

        idle();
        rst_i = 1'b1;
        #1;
        chk("rst_from_halt", {31'd0, halted_o}, 32'd0);
        chk("rst_from_halt_stat", {28'd0, stat_o}, 32'h1);
        chk_cnt("rst_from_halt", 32'd0, 16'd0, 16'd0);
        chk_ctl("rst_from_halt_ctl", 6'b000000);
        @(negedge clk_i);
        rst_i = 1'b0;

        E_icode_i = 4'h5; E_dstM_i = 4'h0; d_srcA_i = 4'h0;
        for (int i = 0; i < 65540; i++) @(posedge clk_i);
        #1 chk_cnt("sat", 32'd65540, 16'hFFFF, 16'hFFFF);
        idle();
        tick();
        chk_cnt("sat_idle", 32'd65541, 16'hFFFF, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
